// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte width and the
// request/acknowledge sink state encoding.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_ACK  = 2'd2
   } rx_state_e;

endpackage

// File: rtl/uart_req_ack_sink.sv
// Four-phase req/ack sink for the UART receiver handshake.
// Ports: clk, rst (async, active low), req in; ack (registered), wr_stb out.
module uart_req_ack_sink
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic ack,
   output logic wr_stb
);

   rx_state_e state;

   // SYNC swallows a req that was already high when reset released,
   // so it can never be taken as a fresh byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_SYNC;
         ack   <= 1'b0;
      end else begin
         unique case (state)
            ST_SYNC: begin
               if (!req) state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (req) begin
                  state <= ST_ACK;
                  ack   <= 1'b1;
               end
            end
            ST_ACK: begin
               if (!req) begin
                  state <= ST_IDLE;
                  ack   <= 1'b0;
               end
            end
            default: begin
               state <= ST_SYNC;
               ack   <= 1'b0;
            end
         endcase
      end
   end

   // Capture happens on the same edge that moves IDLE to ACK.
   assign wr_stb = (state == ST_IDLE) && req;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART req/ack handshake, with overrun flag.
// Ports: in_data/in_req/in_ack handshake, rd_en/rd_data/rd_valid read port,
// empty/full/count status, sticky overrun with clr_ovr.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int depth = 16,
   parameter int aw    = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_req,
   output logic              in_ack,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [aw:0]       count,
   output logic              overrun,
   input  logic              clr_ovr
);

   localparam logic [aw:0] FULL_CNT = (aw+1)'(depth);

   logic              wr_stb;
   logic              rd_fire;
   logic              wr_ok;
   logic              drop;
   logic [aw:0]       count_nxt;
   logic [aw-1:0]     wptr;
   logic [aw-1:0]     rptr;
   logic [BYTE_W-1:0] mem [depth];

   uart_req_ack_sink u_sink (
      .clk    (clk),
      .rst    (rst),
      .req    (in_req),
      .ack    (in_ack),
      .wr_stb (wr_stb)
   );

   // A read in the same cycle frees the slot for the incoming byte.
   assign rd_fire = rd_en && !empty;
   assign wr_ok   = wr_stb && (!full || rd_fire);
   assign drop    = wr_stb && !wr_ok;

   always_comb begin
      count_nxt = count;
      if (wr_ok && !rd_fire) begin
         count_nxt = count + 1'b1;
      end else if (!wr_ok && rd_fire) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_fire) begin
            rptr    <= rptr + 1'b1;
            rd_data <= mem[rptr];
         end
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == FULL_CNT);
         // Set wins over a simultaneous clear.
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_ovr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with a queue-based reference model.
// Directed scenarios followed by a randomized mix of writes, reads, clears.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_req = 1'b0;
   logic       in_ack;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
   logic       clr_ovr = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] model_q[$];
   logic [7:0] exp_out[$];
   bit         m_ovr = 1'b0;
   logic [7:0] mon_e;
   logic [7:0] last_rd;

   uart_rx_fifo #(.depth(DEPTH), .aw(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_req   (in_req),
      .in_ack   (in_ack),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overrun  (overrun),
      .clr_ovr  (clr_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, " count"}, int'(count), model_q.size());
      chk({tag, " empty"}, int'(empty), int'(model_q.size() == 0));
      chk({tag, " full"}, int'(full), int'(model_q.size() == DEPTH));
      chk({tag, " overrun"}, int'(overrun), int'(m_ovr));
   endtask

   // Monitor: every rd_valid pulse must match the oldest expected byte.
   always @(negedge clk) begin
      if (rst && rd_valid) begin
         if (exp_out.size() == 0) begin
            chk("rd_valid unexpected", 1, 0);
         end else begin
            mon_e = exp_out.pop_front();
            chk("rd_data", int'(rd_data), int'(mon_e));
         end
      end
   end

   // Offer one byte; optional read and overrun clear on the capture edge.
   task automatic send(input logic [7:0] b, input bit with_rd,
                       input bit with_clr);
      bit rf;
      bit dropped;
      in_data = b;
      in_req  = 1'b1;
      rd_en   = with_rd;
      clr_ovr = with_clr;
      rf = with_rd && (model_q.size() > 0);
      if (rf) exp_out.push_back(model_q.pop_front());
      dropped = (model_q.size() >= DEPTH);
      if (!dropped) model_q.push_back(b);
      if (dropped) m_ovr = 1'b1;
      else if (with_clr) m_ovr = 1'b0;
      @(negedge clk);
      rd_en   = 1'b0;
      clr_ovr = 1'b0;
      in_data = 8'($urandom);
      chk("ack rise", int'(in_ack), 1);
      chk("rd_valid on send", int'(rd_valid), int'(rf));
      in_req = 1'b0;
      @(negedge clk);
      chk("ack fall", int'(in_ack), 0);
   endtask

   task automatic rd();
      bit rf;
      rd_en = 1'b1;
      rf = (model_q.size() > 0);
      if (rf) exp_out.push_back(model_q.pop_front());
      @(negedge clk);
      rd_en = 1'b0;
      chk("rd_valid on read", int'(rd_valid), int'(rf));
   endtask

   task automatic clr();
      clr_ovr = 1'b1;
      m_ovr = 1'b0;
      @(negedge clk);
      clr_ovr = 1'b0;
   endtask

   initial begin
      int r;
      repeat (2) @(negedge clk);
      chk("reset in_ack", int'(in_ack), 0);
      chk("reset rd_data", int'(rd_data), 0);
      chk("reset rd_valid", int'(rd_valid), 0);
      chk_state("reset");
      rst = 1'b1;
      @(negedge clk);

      // single byte
      send(8'h55, 1'b0, 1'b0);
      chk_state("single");
      rd();
      chk_state("single read");

      // order and wrap
      send(8'h55, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0);
      send(8'hB3, 1'b0, 1'b0);
      repeat (3) rd();
      for (int i = 0; i < 20; i++) begin
         send(8'(i), 1'b0, 1'b0);
         rd();
      end
      chk_state("wrap");

      // full and overrun
      for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 1'b0);
      chk_state("full");
      send(8'hAA, 1'b0, 1'b0);
      chk_state("overrun");
      repeat (DEPTH) rd();
      chk_state("drained");
      clr();
      chk_state("cleared");

      // simultaneous write and read at full
      for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 1'b0);
      send(8'h77, 1'b1, 1'b0);
      chk_state("full simult");
      repeat (DEPTH) rd();
      chk_state("simult drained");

      // empty read
      last_rd = rd_data;
      rd();
      chk("empty read rd_data", int'(rd_data), int'(last_rd));
      chk_state("empty read");

      // drop and clear in the same cycle: drop wins
      for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 1'b0);
      send(8'hE1, 1'b0, 1'b1);
      chk_state("set wins");
      repeat (DEPTH) rd();
      clr();

      // reset mid-handshake
      in_data = 8'h99;
      in_req  = 1'b1;
      @(negedge clk);
      chk("pre-reset ack", int'(in_ack), 1);
      #2 rst = 1'b0;
      #1 chk("async ack drop", int'(in_ack), 0);
      model_q.delete();
      exp_out.delete();
      m_ovr = 1'b0;
      @(negedge clk);
      chk("ack in reset", int'(in_ack), 0);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("ack after reset", int'(in_ack), 0);
         chk("count after reset", int'(count), 0);
      end
      in_req = 1'b0;
      @(negedge clk);
      send(8'h3C, 1'b0, 1'b0);
      chk_state("post reset");
      rd();
      chk_state("post reset read");

      // randomized mix
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4) send(8'($urandom), 1'b0, 1'b0);
         else if (r < 6) send(8'($urandom), 1'b1, 1'($urandom));
         else if (r < 9) rd();
         else clr();
         chk_state("random");
      end
      while (model_q.size() > 0) rd();
      @(negedge clk);
      chk("scoreboard drained", exp_out.size(), 0);
      chk_state("final");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
